// File: rtl/ctl_shot.sv
// Shot controller: edge-detected trigger, snapshot hit test, ammo accounting and frame-paced cooldown.
// Optional macro CTL_SHOT_INF_AMMO_EN: ammunition is never consumed and COOLDOWN always re-arms.
module ctl_shot #(
  parameter int DUCK_W          = 64,
  parameter int DUCK_H          = 64,
  parameter int SHOTS           = 3,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_frame,
  input  logic        round_start,
  input  logic        mouse_left,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic [10:0] duck_x,
  input  logic [10:0] duck_y,
  input  logic        duck_show,
  output logic        shot_fired,
  output logic        duck_hit,
  output logic        shot_miss,
  output logic [1:0]  shots_left,
  output logic [3:0]  hit_cnt,
  output logic        out_of_ammo
);

  typedef enum logic [2:0] {
    S_EMPTY, S_ARMED, S_EVAL, S_HIT_HOLD, S_COOLDOWN
  } state_e;

  localparam logic [12:0] W13  = 13'(DUCK_W);
  localparam logic [12:0] H13  = 13'(DUCK_H);
  localparam logic [5:0]  CD6  = 6'(COOLDOWN_FRAMES);
  localparam logic [1:0]  AMMO = 2'(SHOTS);

  state_e      state_q, state_d;
  logic        mouse_left_q;
  logic [11:0] mx_q, mx_d, my_q, my_d;
  logic [10:0] dx_q, dx_d, dy_q, dy_d;
  logic        show_q, show_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  shots_q, shots_d;
  logic [3:0]  hit_cnt_q, hit_cnt_d;
  logic        duck_hit_q, duck_hit_d;
  logic        fired_q, fired_d;
  logic        miss_q, miss_d;
  logic        ooa_q;
  logic        click;
  logic        hit;

  assign click = mouse_left & ~mouse_left_q;

  // 13-bit compare so dx + DUCK_W cannot wrap near the right/bottom edge.
  assign hit = show_q
            && ({1'b0, mx_q} >= {2'b0, dx_q}) && ({1'b0, mx_q} < ({2'b0, dx_q} + W13))
            && ({1'b0, my_q} >= {2'b0, dy_q}) && ({1'b0, my_q} < ({2'b0, dy_q} + H13));

  always_comb begin
    state_d    = state_q;
    mx_d       = mx_q;
    my_d       = my_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    show_d     = show_q;
    cnt_d      = cnt_q;
    shots_d    = shots_q;
    hit_cnt_d  = hit_cnt_q;
    duck_hit_d = duck_hit_q;
    fired_d    = 1'b0;
    miss_d     = 1'b0;
    if (round_start) begin
      state_d    = S_ARMED;
      shots_d    = AMMO;
      duck_hit_d = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (click) begin
            mx_d    = mouse_x;
            my_d    = mouse_y;
            dx_d    = duck_x;
            dy_d    = duck_y;
            show_d  = duck_show;
`ifndef CTL_SHOT_INF_AMMO_EN
            shots_d = shots_q - 2'd1;
`endif
            fired_d = 1'b1;
            state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          if (hit) begin
            duck_hit_d = 1'b1;
            if (hit_cnt_q != 4'hF) hit_cnt_d = hit_cnt_q + 4'd1;
            state_d = S_HIT_HOLD;
          end else begin
            miss_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          if (new_frame) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_d == CD6) begin
`ifdef CTL_SHOT_INF_AMMO_EN
              state_d = S_ARMED;
`else
              state_d = (shots_q != 2'd0) ? S_ARMED : S_EMPTY;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      mouse_left_q <= 1'b0;
      mx_q         <= '0;
      my_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      show_q       <= 1'b0;
      cnt_q        <= '0;
      shots_q      <= '0;
      hit_cnt_q    <= '0;
      duck_hit_q   <= 1'b0;
      fired_q      <= 1'b0;
      miss_q       <= 1'b0;
      ooa_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      mouse_left_q <= mouse_left;
      mx_q         <= mx_d;
      my_q         <= my_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      show_q       <= show_d;
      cnt_q        <= cnt_d;
      shots_q      <= shots_d;
      hit_cnt_q    <= hit_cnt_d;
      duck_hit_q   <= duck_hit_d;
      fired_q      <= fired_d;
      miss_q       <= miss_d;
      ooa_q        <= (state_d == S_EMPTY);
    end
  end

  assign shot_fired  = fired_q;
  assign duck_hit    = duck_hit_q;
  assign shot_miss   = miss_q;
  assign shots_left  = shots_q;
  assign hit_cnt     = hit_cnt_q;
  assign out_of_ammo = ooa_q;

endmodule

// File: tb/tb_ctl_shot.sv
// Directed bench for ctl_shot: hit/miss geometry, cooldown pacing, ammo, click edges, reset.
module tb_ctl_shot;

`ifdef CTL_SHOT_INF_AMMO_EN
  localparam int DEC = 0;
`else
  localparam int DEC = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_frame = 1'b0;
  logic        round_start = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_x = '0;
  logic [11:0] mouse_y = '0;
  logic [10:0] duck_x = '0;
  logic [10:0] duck_y = '0;
  logic        duck_show = 1'b0;
  logic        shot_fired, duck_hit, shot_miss, out_of_ammo;
  logic [1:0]  shots_left;
  logic [3:0]  hit_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctl_shot dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .round_start(round_start),
    .mouse_left(mouse_left), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .duck_x(duck_x), .duck_y(duck_y), .duck_show(duck_show),
    .shot_fired(shot_fired), .duck_hit(duck_hit), .shot_miss(shot_miss),
    .shots_left(shots_left), .hit_cnt(hit_cnt), .out_of_ammo(out_of_ammo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      tick();
    end
  endtask

  task automatic restart();
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
  endtask

  // Click at (x,y); f/s sampled in cycle N+1, h/m in cycle N+2.
  task automatic fire(input int x, input int y, input bit nf_eval,
                      output logic f, output logic [1:0] s, output logic h, output logic m);
    mouse_x    = 12'(x);
    mouse_y    = 12'(y);
    mouse_left = 1'b1;
    tick();
    f = shot_fired;
    s = shots_left;
    mouse_left = 1'b0;
    new_frame  = nf_eval;
    tick();
    new_frame = 1'b0;
    h = duck_hit;
    m = shot_miss;
  endtask

  logic       f, h, m;
  logic [1:0] s;
  int         n;
  int         exp_hits;

  initial begin
    tick();
    tick();
    chk("rst_out_of_ammo", out_of_ammo, 1);
    chk("rst_shots_left", shots_left, 0);
    chk("rst_duck_hit", duck_hit, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_shot_fired", shot_fired, 0);
    rst = 1'b0;
    tick();

    fire(10, 10, 0, f, s, h, m);
    chk("empty_click_ignored", f, 0);
    chk("empty_out_of_ammo", out_of_ammo, 1);

    restart();
    chk("start_shots_left", shots_left, 3);
    chk("start_out_of_ammo", out_of_ammo, 0);

    duck_x = 11'd100; duck_y = 11'd200; duck_show = 1'b1;
    fire(163, 263, 0, f, s, h, m);
    chk("hit_fired", f, 1);
    chk("hit_shots_left", s, 3 - DEC);
    chk("hit_duck_hit", h, 1);
    chk("hit_no_miss", m, 0);
    chk("hit_cnt_1", hit_cnt, 1);
    exp_hits = 1;
    frames(3);
    fire(120, 220, 0, f, s, h, m);
    chk("hold_click_ignored", f, 0);
    chk("hold_duck_hit_held", h, 1);
    restart();
    chk("restart_duck_hit_clear", duck_hit, 0);
    chk("restart_shots_left", shots_left, 3);

    fire(164, 200, 0, f, s, h, m);
    chk("miss_x_fired", f, 1);
    chk("miss_x_shots_left", s, 3 - DEC);
    chk("miss_x_shot_miss", m, 1);
    chk("miss_x_no_hit", h, 0);
    frames(5);
    fire(120, 220, 0, f, s, h, m);
    chk("cooldown5_click_ignored", f, 0);
    frames(5);

    // new_frame during EVAL must not count toward the cooldown.
    fire(100, 264, 1, f, s, h, m);
    chk("miss_y_fired", f, 1);
    chk("miss_y_shots_left", s, 3 - 2 * DEC);
    chk("miss_y_shot_miss", m, 1);
    chk("miss_y_no_hit", h, 0);
    frames(9);
    fire(120, 220, 0, f, s, h, m);
    chk("cooldown9_click_ignored", f, 0);
    frames(1);

    duck_show = 1'b0;
    fire(120, 220, 0, f, s, h, m);
    chk("miss_hidden_fired", f, 1);
    chk("miss_hidden_shots_left", s, 3 - 3 * DEC);
    chk("miss_hidden_shot_miss", m, 1);
    chk("miss_hidden_no_hit", h, 0);
    frames(10);
    chk("empty_shots_left", shots_left, 3 - 3 * DEC);
    chk("empty_after_cooldown", out_of_ammo, DEC);

`ifdef CTL_SHOT_INF_AMMO_EN
    for (int i = 0; i < 5; i++) begin
      fire(120, 220, 0, f, s, h, m);
      chk("inf_fired", f, 1);
      chk("inf_shot_miss", m, 1);
      frames(10);
    end
    chk("inf_shots_left", shots_left, 3);
    chk("inf_not_empty", out_of_ammo, 0);
    fire(120, 220, 0, f, s, h, m);
    chk("inf_still_armed", f, 1);
    frames(10);
`endif

    restart();
    n = 0;
    mouse_left = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (shot_fired) n++;
    end
    mouse_left = 1'b0;
    chk("held_one_shot", n, 1);
    tick();

    round_start = 1'b1;
    mouse_left  = 1'b1;
    tick();
    round_start = 1'b0;
    chk("collision_no_fire", shot_fired, 0);
    chk("collision_shots_left", shots_left, 3);
    tick();
    chk("collision_edge_consumed", shot_fired, 0);
    mouse_left = 1'b0;
    tick();

    duck_x = 11'd2000; duck_y = 11'd2000; duck_show = 1'b1;
    fire(2047, 2047, 0, f, s, h, m);
    chk("wrap_fired", f, 1);
    chk("wrap_hit", h, 1);
    exp_hits = 2;
    chk("wrap_hit_cnt", hit_cnt, exp_hits);

    for (int i = 0; i < 15; i++) begin
      restart();
      fire(2010, 2010, 0, f, s, h, m);
      if (exp_hits < 15) exp_hits++;
    end
    chk("hit_cnt_saturated", hit_cnt, exp_hits);

    restart();
    mouse_x = 12'd2010; mouse_y = 12'd2010;
    mouse_left = 1'b1;
    tick();
    chk("rst_eval_fired", shot_fired, 1);
    rst = 1'b1;
    mouse_left = 1'b0;
    tick();
    chk("rst_eval_no_hit", duck_hit, 0);
    chk("rst_eval_no_miss", shot_miss, 0);
    chk("rst_eval_out_of_ammo", out_of_ammo, 1);
    chk("rst_eval_hit_cnt", hit_cnt, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_no_hit", duck_hit, 0);
    chk("post_rst_no_miss", shot_miss, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
